act_feed_sequencer: RTL and testbench

ACT_FEED_SEQUENCER -- requirements
Module: act_feed_sequencer

---
 rtl/act_feed_sequencer.sv | 150 +++++++++++++++
 tb/tb_act_feed_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_feed_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_feed_sequencer: per-layer sequencer driving FIFO feed and MAC accum. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module act_feed_sequencer #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT        = 1024,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] NUM_INPUTS,
  input  logic [CNT_W-1:0] NUM_OUTPUTS,
  input  logic             FIFO_EMPTY,
  input  logic             DATA_VALID,
  output logic             CLEAR_FIFO,
  output logic             START_FEED,
  output logic             ACC_CLEAR,
  output logic             ACC_STORE,
  output logic [CNT_W-1:0] OUT_IDX,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_bpw      = CNT_W'(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_ACC_CLR   = 3'd2,
    S_WAIT_FILL = 3'd3,
    S_KICK      = 3'd4,
    S_FEED      = 3'd5,
    S_STORE     = 3'd6,
    S_FINISH    = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_num_in;
  logic [CNT_W-1:0] r_num_out;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] r_out_idx;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_error;

  logic w_cfg_ok;
  logic w_accept;
  logic w_last_byte;
  logic w_timeout;
  logic w_abort;
  logic w_err_set;

  assign w_cfg_ok    = (NUM_INPUTS != '0) && (NUM_OUTPUTS != '0) &&
                       ((NUM_INPUTS % c_bpw) == '0);
  assign w_accept    = (r_state == S_IDLE) && START && w_cfg_ok;
  assign w_last_byte = DATA_VALID && (r_byte_cnt == (r_num_in - c_one));
  assign w_timeout   = (r_state == S_WAIT_FILL) && FIFO_EMPTY && (r_tmo_cnt == c_tmo_last);
  assign w_abort     = (r_state != S_IDLE) && ABORT;

  // Data arriving outside the feed window means the controller overran us.
  assign w_err_set = ((r_state == S_IDLE) && START && !w_cfg_ok) || w_abort || w_timeout ||
                     (DATA_VALID && (r_state != S_KICK) && (r_state != S_FEED));

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_FINISH;
    end else begin
      case (r_state)
        S_IDLE:      if (START) w_next = w_cfg_ok ? S_CLEAR : S_FINISH;
        S_CLEAR:     w_next = S_ACC_CLR;
        S_ACC_CLR:   w_next = S_WAIT_FILL;
        S_WAIT_FILL: begin
          if (!FIFO_EMPTY)    w_next = S_KICK;
          else if (w_timeout) w_next = S_FINISH;
        end
        S_KICK:      w_next = w_last_byte ? S_STORE : S_FEED;
        S_FEED: begin
          if (w_last_byte)                    w_next = S_STORE;
          else if (!DATA_VALID && FIFO_EMPTY) w_next = S_WAIT_FILL;
        end
        S_STORE:     w_next = (r_out_idx == (r_num_out - c_one)) ? S_FINISH : S_ACC_CLR;
        S_FINISH:    w_next = S_IDLE;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state    <= S_IDLE;
      r_num_in   <= '0;
      r_num_out  <= '0;
      r_byte_cnt <= '0;
      r_out_idx  <= '0;
      r_tmo_cnt  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_err_set)     r_error <= 1'b1;
      else if (w_accept) r_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_num_in  <= NUM_INPUTS;
            r_num_out <= NUM_OUTPUTS;
            r_out_idx <= '0;
          end
        end
        S_ACC_CLR: begin
          r_byte_cnt <= '0;
          r_tmo_cnt  <= '0;
        end
        S_WAIT_FILL: begin
          if (FIFO_EMPTY) r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
          else            r_tmo_cnt <= '0;
        end
        S_KICK, S_FEED: begin
          if (DATA_VALID && (r_byte_cnt != r_num_in)) r_byte_cnt <= r_byte_cnt + c_one;
        end
        S_STORE: begin
          if (w_next == S_ACC_CLR) r_out_idx <= r_out_idx + c_one;
        end
        default: ;
      endcase
    end
  end

  assign CLEAR_FIFO = (r_state == S_CLEAR);
  assign ACC_CLEAR  = (r_state == S_ACC_CLR);
  assign START_FEED = (r_state == S_KICK);
  assign ACC_STORE  = (r_state == S_STORE);
  assign BUSY       = (r_state != S_IDLE);
  assign DONE       = (r_state == S_FINISH);
  assign OUT_IDX    = r_out_idx;
  assign ERROR      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_act_feed_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_act_feed_sequencer: directed self-checking bench for the sequencer.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_act_feed_sequencer;

  logic        CLK;
  logic        RESETN;
  logic        START;
  logic        ABORT;
  logic [15:0] NUM_INPUTS;
  logic [15:0] NUM_OUTPUTS;
  logic        FIFO_EMPTY;
  logic        DATA_VALID;
  logic        CLEAR_FIFO;
  logic        START_FEED;
  logic        ACC_CLEAR;
  logic        ACC_STORE;
  logic [15:0] OUT_IDX;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  int n_asserts = 0;
  int n_fail    = 0;

  // Output vector order: CLEAR_FIFO, ACC_CLEAR, START_FEED, ACC_STORE, BUSY, DONE, ERROR
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_CLR   = 7'b1000100;
  localparam logic [6:0] O_ACLR  = 7'b0100100;
  localparam logic [6:0] O_KICK  = 7'b0010100;
  localparam logic [6:0] O_BUSY  = 7'b0000100;
  localparam logic [6:0] O_STORE = 7'b0001100;
  localparam logic [6:0] O_FIN   = 7'b0000110;
  localparam logic [6:0] O_ERR   = 7'b0000001;

  logic [6:0] obs;
  assign obs = {CLEAR_FIFO, ACC_CLEAR, START_FEED, ACC_STORE, BUSY, DONE, ERROR};

  act_feed_sequencer #(
    .CNT_W          (16),
    .TIMEOUT        (16),
    .BYTES_PER_WORD (4)
  ) u_dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .START       (START),
    .ABORT       (ABORT),
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .DATA_VALID  (DATA_VALID),
    .CLEAR_FIFO  (CLEAR_FIFO),
    .START_FEED  (START_FEED),
    .ACC_CLEAR   (ACC_CLEAR),
    .ACC_STORE   (ACC_STORE),
    .OUT_IDX     (OUT_IDX),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, obs}, {25'd0, exp});
  endtask

  // Presents n valid bytes, one per cycle; all but the last leave the block in FEED.
  task automatic feed(input int n, input logic [6:0] last_exp, input logic err, input string tag);
    for (int i = 1; i <= n; i++) begin
      DATA_VALID = 1'b1;
      tick();
      if (i == n) chk_o(tag, last_exp);
      else        chk_o(tag, O_BUSY | {6'd0, err});
    end
    DATA_VALID = 1'b0;
  endtask

  // Drives START with the given counts and walks CLEAR, ACC_CLR into WAIT_FILL.
  task automatic begin_layer(input logic [15:0] ni, input logic [15:0] no, input string tag);
    NUM_INPUTS  = ni;
    NUM_OUTPUTS = no;
    START       = 1'b1;
    tick();
    chk_o({tag, "_clear"}, O_CLR);
    START = 1'b0;
    tick();
    chk_o({tag, "_accclr"}, O_ACLR);
    tick();
    chk_o({tag, "_wait"}, O_BUSY);
  endtask

  initial begin
    RESETN      = 1'b0;
    START       = 1'b0;
    ABORT       = 1'b0;
    NUM_INPUTS  = '0;
    NUM_OUTPUTS = '0;
    FIFO_EMPTY  = 1'b1;
    DATA_VALID  = 1'b0;
    tick();
    tick();
    chk_o("reset_outs", O_IDLE);
    chk("reset_idx", {16'd0, OUT_IDX}, 32'd0);

    // Two neurons, FIFO pre-filled; START on the first cycle out of reset.
    RESETN     = 1'b1;
    FIFO_EMPTY = 1'b0;
    begin_layer(16'd8, 16'd2, "A");
    tick();
    chk_o("A_kick0", O_KICK);
    feed(8, O_STORE, 1'b0, "A_feed0");
    chk("A_idx0", {16'd0, OUT_IDX}, 32'd0);
    START      = 1'b1;
    NUM_INPUTS = 16'd4;
    tick();
    chk_o("A_accclr1", O_ACLR);
    chk("A_idx1", {16'd0, OUT_IDX}, 32'd1);
    tick();
    chk_o("A_wait1", O_BUSY);
    tick();
    chk_o("A_kick1", O_KICK);
    feed(8, O_STORE, 1'b0, "A_feed1");
    chk("A_store_idx1", {16'd0, OUT_IDX}, 32'd1);
    START      = 1'b0;
    FIFO_EMPTY = 1'b1;
    tick();
    chk_o("A_finish", O_FIN);
    chk("A_fin_idx", {16'd0, OUT_IDX}, 32'd1);
    tick();
    chk_o("A_idle", O_IDLE);
    chk("A_idle_idx", {16'd0, OUT_IDX}, 32'd1);

    ABORT = 1'b1;
    tick();
    chk_o("idle_abort_ignored", O_IDLE);
    ABORT = 1'b0;

    // One word, underrun, refill later, second kick.
    FIFO_EMPTY = 1'b0;
    begin_layer(16'd8, 16'd1, "B");
    tick();
    chk_o("B_kick0", O_KICK);
    feed(4, O_BUSY, 1'b0, "B_feed0");
    FIFO_EMPTY = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_o("B_refill_wait", O_BUSY);
    end
    FIFO_EMPTY = 1'b0;
    tick();
    chk_o("B_kick1", O_KICK);
    feed(4, O_STORE, 1'b0, "B_feed1");
    chk("B_idx", {16'd0, OUT_IDX}, 32'd0);
    FIFO_EMPTY = 1'b1;
    tick();
    chk_o("B_finish", O_FIN);
    tick();
    chk_o("B_idle", O_IDLE);

    // Bad configurations finish immediately with ERROR.
    NUM_INPUTS  = 16'd6;
    NUM_OUTPUTS = 16'd1;
    START       = 1'b1;
    tick();
    chk_o("C_bad_ni_done", O_FIN | O_ERR);
    START = 1'b0;
    tick();
    chk_o("C_bad_ni_idle", O_ERR);
    NUM_INPUTS  = 16'd8;
    NUM_OUTPUTS = 16'd0;
    START       = 1'b1;
    tick();
    chk_o("C_bad_no_done", O_FIN | O_ERR);
    START = 1'b0;
    tick();
    chk_o("C_bad_no_idle", O_ERR);

    // FIFO never fills: DONE 16 cycles after WAIT_FILL entry.
    FIFO_EMPTY = 1'b1;
    begin_layer(16'd8, 16'd1, "D");
    for (int k = 1; k < 16; k++) begin
      tick();
      chk_o("D_waiting", O_BUSY);
    end
    tick();
    chk_o("D_timeout", O_FIN | O_ERR);
    tick();
    chk_o("D_idle", O_ERR);

    // Abort after 3 bytes, then a clean layer started alongside ABORT.
    FIFO_EMPTY = 1'b0;
    begin_layer(16'd8, 16'd1, "E");
    tick();
    chk_o("E_kick", O_KICK);
    feed(3, O_BUSY, 1'b0, "E_feed");
    ABORT = 1'b1;
    tick();
    chk_o("E_abort_done", O_FIN | O_ERR);
    ABORT = 1'b0;
    tick();
    chk_o("E_abort_idle", O_ERR);
    ABORT       = 1'b1;
    START       = 1'b1;
    tick();
    chk_o("E_start_with_abort", O_CLR);
    ABORT = 1'b0;
    START = 1'b0;
    tick();
    chk_o("E2_accclr", O_ACLR);
    tick();
    chk_o("E2_wait", O_BUSY);
    tick();
    chk_o("E2_kick", O_KICK);
    feed(8, O_STORE, 1'b0, "E2_feed");
    FIFO_EMPTY = 1'b1;
    tick();
    chk_o("E2_clean_done", O_FIN);
    tick();
    chk_o("E2_idle", O_IDLE);

    // Data while waiting is an overrun: ERROR set, flow unchanged.
    FIFO_EMPTY = 1'b1;
    begin_layer(16'd8, 16'd1, "F");
    DATA_VALID = 1'b1;
    tick();
    chk_o("F_overrun", O_BUSY | O_ERR);
    DATA_VALID = 1'b0;
    FIFO_EMPTY = 1'b0;
    tick();
    chk_o("F_kick", O_KICK | O_ERR);
    feed(8, O_STORE | O_ERR, 1'b1, "F_feed");
    FIFO_EMPTY = 1'b1;
    tick();
    chk_o("F_done", O_FIN | O_ERR);
    tick();
    chk_o("F_idle", O_ERR);

    // Reset during STORE: everything low, no DONE afterwards.
    FIFO_EMPTY = 1'b0;
    begin_layer(16'd8, 16'd1, "G");
    tick();
    chk_o("G_kick", O_KICK);
    feed(8, O_STORE, 1'b0, "G_feed");
    RESETN = 1'b0;
    tick();
    chk_o("G_reset_outs", O_IDLE);
    chk("G_reset_idx", {16'd0, OUT_IDX}, 32'd0);
    RESETN = 1'b1;
    tick();
    chk_o("G_no_done", O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
